dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the RV32 core: the memory-side end of the pipeline's data-memory port. It accepts the enable, byte write-strobes, byte address and lane-aligned store data driven by the memory stage. It performs byte-masked writes or full-word reads into a synchronous word array and returns registered read data with a valid pulse. Optional wait states are inserted through a ready handshake, so slower memory timing can be modelled without changing the core.

## Interface
- `ADDR_W`, 10, word-address width; array depth is 2^ADDR_W 32-bit words.
- `WAIT_CYC`, 0, extra wait cycles per access; legal range 0–15.
- `clk_i` input 1: single clock; all state changes on the rising edge.
- `rst_n_i` input 1: reset, asynchronous and active-low.
- `dmemen_i` input 1: access request.
- `dmemwe_i` input 4: byte write-strobes, where bit n writes byte lane n. If all strobes are 0 while `dmemen_i`=1, the access is a read.
- `addr_i` input 32: byte address.
  - Word index is `addr_i[ADDR_W+1:2]`.
  - `addr_i[1:0]` is ignored.
- `wdata_i` input 32: store data, already lane-aligned upstream.
- `ready_o` output 1: responder can accept a request this cycle.
- `rdata_o` output 32: registered read word.
- `rvalid_o` output 1: one-cycle pulse; `rdata_o` holds a new read result.
- `err_o` output 1: one-cycle pulse; the completed access was out of range.

## Operation
- **Accept:** a request is accepted on a rising edge where `dmemen_i`=1 and `ready_o`=1. On accept, the block latches:
  - the word index,
  - the strobes,
  - `wdata_i`,
  - the range flag.
- **Range check:** an access is out of range when `addr_i[31:ADDR_W+2]` is nonzero. For such an access:
  - the write is suppressed and no array byte changes;
  - a read returns 0 with `rvalid_o`=1;
  - `err_o`=1 in the completion cycle.
- **Write:** only the lanes with a set strobe are updated; the other lanes keep their old value. A write never asserts `rvalid_o`.
- **Read:** always returns the full 32-bit word. Lane selection and sign/zero extension are done by the load unit upstream.
- **`rdata_o` hold:** `rdata_o` keeps its value until the next read completes; writes leave it unchanged.
- **State machine (WAIT_CYC>0):**
  - IDLE: `ready_o`=1. On accept, go to WAIT and load counter = WAIT_CYC.
  - WAIT: `ready_o`=0 and requests are ignored. Each cycle the counter decrements. On the edge where counter==1, the access is performed and the state returns to IDLE.
- **WAIT_CYC=0:** the block stays in IDLE permanently and performs the access on the accept edge itself. Back-to-back requests run at full rate.
- **Array reset:** array contents are not reset; reads of never-written words return X.
- **Input stability:** `dmemen_i`, `dmemwe_i`, `addr_i` and `wdata_i` may change freely while `ready_o`=0; they have no effect.
- **Mid-operation reset:** asserting `rst_n_i` during WAIT aborts the pending access. A pending write is discarded, with no partial byte update.

## Timing
- **Reset values:**
  - `ready_o`=1
  - `rdata_o`=32'h0
  - `rvalid_o`=0
  - `err_o`=0
  - state = IDLE, counter = 0
- **Write commit:** accept in cycle N, with the array updated at the end of cycle N+WAIT_CYC.
- **Read latency:** accept in cycle N; `rdata_o`/`rvalid_o` are valid in cycle N+WAIT_CYC+1 and `rvalid_o` falls the following cycle unless another read completes.
- **`ready_o` timing:** `ready_o` is low in cycles N+1 … N+WAIT_CYC and high again in cycle N+WAIT_CYC+1. That is the same cycle as read data, so the next request can be accepted then.
- **Read-after-write:** a read accepted in the first cycle `ready_o` is high after a write completes observes the written bytes. No forwarding path is needed, since there is a single port and one outstanding access.
- **`err_o` timing:** `err_o` aligns with the completion cycle: the same cycle as `rvalid_o` for reads, and cycle N+WAIT_CYC+1 for writes.

## Test plan
- **Write then read, WAIT_CYC=0:** write `addr_i`=32'h10, strobes 4'hF, data 32'hDEADBEEF in cycle N, then read 32'h10 in cycle N+1. Required: `rdata_o`=32'hDEADBEEF with `rvalid_o`=1 in cycle N+2, and `ready_o` stays 1 throughout.
- **Byte-lane write:** preload 32'h11223344 at 32'h20, then write strobes 4'b0100 with data 32'h00AA0000. A read must return 32'h11AA3344.
- **Out of range, ADDR_W=10:** write 32'hFFFFFFFF to `addr_i`=32'h1000, then read it. Required:
  - `err_o` pulses for both accesses;
  - the read returns 0 with `rvalid_o`=1;
  - a read of word 0 is unchanged.
- **Wait states, WAIT_CYC=2:** read accepted in cycle N. Required: `ready_o`=0 in N+1 and N+2, and `rvalid_o` with data in N+3 and `ready_o`=1 in N+3. A `dmemen_i` pulse in N+1 must be ignored.
- **Reset mid-wait, WAIT_CYC=3:** write 32'hCAFEF00D to 32'h40, with `rst_n_i` low in cycle N+1. Required: all outputs return to reset values immediately, and a later read of 32'h40 shows the pre-write contents.
- **Back-to-back reads, WAIT_CYC=0:** reads of 32'h10, 32'h20, 32'h10 in consecutive cycles. Required: `rvalid_o` high for 3 consecutive cycles with the matching words in order.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side end of the RV32 data-memory port. Performs byte-masked
//   writes or full-word reads on a synchronous word array, returns registered
//   read data with a one-cycle valid pulse, and can stretch each access by
//   WAIT_CYC cycles through the ready handshake.
//
// Handshake: a request is accepted on a rising edge where dmemen_i=1 and
//   ready_o=1. While ready_o=0 all request inputs are ignored. Completion is
//   signalled by rvalid_o (reads only) and err_o (out-of-range, reads and
//   writes), each a one-cycle pulse in the completion cycle.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   dmemen_i     access request
//   dmemwe_i     byte write strobes (all zero = read)
//   addr_i       byte address; word index = addr_i[ADDR_W+1:2]
//   wdata_i      lane-aligned store data
//   ready_o      request can be accepted this cycle
//   rdata_o      registered read word, held until the next read completes
//   rvalid_o     read completion pulse
//   err_o        out-of-range completion pulse
//   dbg_state_o  current FSM state (0 = IDLE, 1 = WAIT)
module dmem_responder #(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        dmemen_i,
  input  logic [3:0]  dmemwe_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic [31:0] rdata_o,
  output logic        rvalid_o,
  output logic        err_o,
  output logic        dbg_state_o
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);
  localparam int         DEPTH   = 1 << ADDR_W;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;

  // Request captured at accept time; used when the access completes later.
  logic [ADDR_W-1:0]   lat_idx;
  logic [3:0]          lat_we;
  logic [31:0]         lat_wdata;
  logic                lat_oor;

  // The access actually performed on this edge (live request or latched one).
  logic                do_access;
  logic [ADDR_W-1:0]   acc_idx;
  logic [3:0]          acc_we;
  logic [31:0]         acc_wdata;
  logic                acc_oor;

  logic [ADDR_W-1:0]   req_idx;
  logic                req_oor;
  logic                accept;

  logic [31:0]         mem [0:DEPTH-1];

  logic [31:0]         rdata_q;
  logic                rvalid_q;
  logic                err_q;

  // Byte offset bits play no part in a full-word access.
  logic                unused_addr_bits;
  assign unused_addr_bits = ^addr_i[1:0];

  assign req_idx = addr_i[ADDR_W+1:2];
  assign req_oor = |addr_i[31:ADDR_W+2];
  assign accept  = (state_q == S_IDLE) && dmemen_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, ready, and selection of the access performed this edge.
  // With WAIT_CYC=0 the WAIT state is never entered and the live request is
  // performed on its own accept edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_o   = 1'b0;
    do_access = 1'b0;
    acc_idx   = lat_idx;
    acc_we    = lat_we;
    acc_wdata = lat_wdata;
    acc_oor   = lat_oor;
    case (state_q)
      S_IDLE: begin
        ready_o = 1'b1;
        if (dmemen_i) begin
          if (WAIT_CYC == 0) begin
            do_access = 1'b1;
            acc_idx   = req_idx;
            acc_we    = dmemwe_i;
            acc_wdata = wdata_i;
            acc_oor   = req_oor;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LD;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          do_access = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Request capture; reset clears it so an aborted access leaves nothing behind.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lat_idx   <= '0;
      lat_we    <= 4'd0;
      lat_wdata <= 32'd0;
      lat_oor   <= 1'b0;
    end else if (accept) begin
      lat_idx   <= req_idx;
      lat_we    <= dmemwe_i;
      lat_wdata <= wdata_i;
      lat_oor   <= req_oor;
    end
  end

  // Word array, byte-lane writes, contents not reset.
  always_ff @(posedge clk_i) begin
    if (do_access && !acc_oor) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_we[b]) begin
          mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

  // Completion outputs. rdata only moves when a read completes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdata_q  <= 32'd0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= do_access && (acc_we == 4'd0);
      err_q    <= do_access && acc_oor;
      if (do_access && (acc_we == 4'd0)) begin
        rdata_q <= acc_oor ? 32'd0 : mem[acc_idx];
      end
    end
  end

  assign rdata_o     = rdata_q;
  assign rvalid_o    = rvalid_q;
  assign err_o       = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder. Two instances share clock and reset: index 0 has
// no wait states, index 1 has two. Expected completions are pushed at issue
// time from a word/byte-lane memory model; a negedge monitor pops and checks.
module tb_dmem_responder;

  localparam int AW = 10;

  logic        clk;
  logic        rst_n;
  logic        en     [2];
  logic [3:0]  we     [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic        ready  [2];
  logic [31:0] rdata  [2];
  logic        rvalid [2];
  logic        err    [2];
  logic        st     [2];

  dmem_responder #(.ADDR_W(AW), .WAIT_CYC(0)) u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .dmemen_i(en[0]), .dmemwe_i(we[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .ready_o(ready[0]), .rdata_o(rdata[0]),
    .rvalid_o(rvalid[0]), .err_o(err[0]), .dbg_state_o(st[0])
  );

  dmem_responder #(.ADDR_W(AW), .WAIT_CYC(2)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .dmemen_i(en[1]), .dmemwe_i(we[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .ready_o(ready[1]), .rdata_o(rdata[1]),
    .rvalid_o(rvalid[1]), .err_o(err[1]), .dbg_state_o(st[1])
  );

  // ---------------- clock / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  int          wcyc   [2];
  int          acc    [2];
  logic [31:0] exp_rdata [2];
  // entry: {due cycle[65:34], is_read[33], err[32], data[31:0]}
  logic [65:0] exp_q0 [$];
  logic [65:0] exp_q1 [$];
  logic [31:0] mdl [int];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: actual %h required %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q0.delete();
    exp_q1.delete();
    acc[0] = -100;
    acc[1] = -100;
    exp_rdata[0] = 32'd0;
    exp_rdata[1] = 32'd0;
  endtask

  // ---------------- monitor ----------------
  task automatic mon(int d);
    logic [65:0] f;
    bit          has;
    logic        exp_rv, exp_er, exp_rdy;
    has = 1'b0;
    f   = '0;
    if (d == 0 && exp_q0.size() > 0) begin f = exp_q0[0]; has = 1'b1; end
    if (d == 1 && exp_q1.size() > 0) begin f = exp_q1[0]; has = 1'b1; end
    exp_rv = 1'b0;
    exp_er = 1'b0;
    if (has && f[65:34] <= 32'(cyc)) begin
      if (d == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
      if (f[65:34] < 32'(cyc)) begin
        checks++;
        errors++;
        $display("FAIL late_completion%0d: due %0d now %0d", d, f[65:34], cyc);
      end
      exp_rv = f[33];
      exp_er = f[32];
      if (f[33]) exp_rdata[d] = f[31:0];
    end
    exp_rdy = !(cyc > acc[d] && cyc <= acc[d] + wcyc[d]);
    check($sformatf("rvalid%0d", d), {31'd0, rvalid[d]}, {31'd0, exp_rv});
    check($sformatf("err%0d", d),    {31'd0, err[d]},    {31'd0, exp_er});
    check($sformatf("ready%0d", d),  {31'd0, ready[d]},  {31'd0, exp_rdy});
    check($sformatf("state%0d", d),  {31'd0, st[d]},     {31'd0, !exp_rdy});
    check($sformatf("rdata%0d", d),  rdata[d],           exp_rdata[d]);
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // ---------------- driver ----------------
  // Called just after a rising edge; returns one cycle later with en low.
  task automatic issue(int d, logic [31:0] a, logic [3:0] s, logic [31:0] dat, bit commit);
    int          guard;
    bit          oor;
    int          key;
    logic [31:0] rd;
    logic [31:0] due;
    guard = 0;
    while (cyc <= acc[d] + wcyc[d]) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 40) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout%0d: waited %0d cycles", d, guard);
        break;
      end
    end
    en[d]    = 1'b1;
    we[d]    = s;
    addr[d]  = a;
    wdata[d] = dat;
    acc[d]   = cyc;
    oor      = (a[31:AW+2] != '0);
    key      = d * 65536 + int'(a[AW+1:2]);
    rd       = 32'd0;
    if (s == 4'd0) begin
      if (!oor) rd = mdl.exists(key) ? mdl[key] : 32'hxxxxxxxx;
    end else if (!oor && commit) begin
      rd = mdl.exists(key) ? mdl[key] : 32'd0;
      for (int b = 0; b < 4; b++)
        if (s[b]) rd[8*b +: 8] = dat[8*b +: 8];
      mdl[key] = rd;
      rd = 32'd0;
    end
    due = 32'(cyc + wcyc[d] + 1);
    if (d == 0) exp_q0.push_back({due, (s == 4'd0), oor, rd});
    else        exp_q1.push_back({due, (s == 4'd0), oor, rd});
    @(posedge clk); #1;
    en[d] = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_outputs(string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_ready%0d", tag, d),  {31'd0, ready[d]},  32'd1);
      check($sformatf("%s_rvalid%0d", tag, d), {31'd0, rvalid[d]}, 32'd0);
      check($sformatf("%s_err%0d", tag, d),    {31'd0, err[d]},    32'd0);
      check($sformatf("%s_rdata%0d", tag, d),  rdata[d],           32'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    int          guard;
    wcyc[0] = 0;
    wcyc[1] = 2;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      en[d] = 1'b0; we[d] = 4'd0; addr[d] = 32'd0; wdata[d] = 32'd0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // ---- dut0: write then read, lanes, out of range, back-to-back ----
    issue(0, 32'h0000_0000, 4'hF, 32'h5A5A_5A5A, 1'b1);
    issue(0, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 1'b1);
    issue(0, 32'h0000_0010, 4'h0, 32'h0, 1'b1);
    idle(1);
    issue(0, 32'h0000_0020, 4'hF, 32'h1122_3344, 1'b1);
    issue(0, 32'h0000_0022, 4'b0100, 32'h00AA_0000, 1'b1);
    issue(0, 32'h0000_0020, 4'h0, 32'h0, 1'b1);
    idle(2);
    issue(0, 32'h0000_1000, 4'hF, 32'hFFFF_FFFF, 1'b1);
    issue(0, 32'h0000_1000, 4'h0, 32'h0, 1'b1);
    issue(0, 32'h0000_0000, 4'h0, 32'h0, 1'b1);
    idle(2);
    issue(0, 32'h0000_0010, 4'h0, 32'h0, 1'b1);
    issue(0, 32'h0000_0020, 4'h0, 32'h0, 1'b1);
    issue(0, 32'h0000_0010, 4'h0, 32'h0, 1'b1);
    idle(3);

    // ---- dut1: wait states with an ignored pulse ----
    issue(1, 32'h0000_0010, 4'hF, 32'h0BAD_F00D, 1'b1);
    issue(1, 32'h0000_0010, 4'h0, 32'h0, 1'b1);
    en[1] = 1'b1; we[1] = 4'hF; addr[1] = 32'h0000_0010; wdata[1] = 32'h0;
    @(posedge clk); #1;
    en[1] = 1'b0;
    issue(1, 32'h0000_0010, 4'h0, 32'h0, 1'b1);
    idle(4);

    // ---- dut1: reset during WAIT aborts a write ----
    issue(1, 32'h0000_0040, 4'hF, 32'h1234_5678, 1'b1);
    issue(1, 32'h0000_0040, 4'hF, 32'hCAFE_F00D, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1 check_reset_outputs("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    issue(1, 32'h0000_0040, 4'h0, 32'h0, 1'b1);
    idle(4);

    // ---- randomized traffic on both instances ----
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++)
        issue(d, 32'(i * 4), 4'hF, $urandom, 1'b1);
      for (int i = 0; i < 60; i++) begin
        if ($urandom_range(0, 5) == 0) begin
          a = $urandom;
          if (a[31:AW+2] == '0) a[31] = 1'b1;
        end else begin
          a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
        end
        issue(d, a, ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
              $urandom, 1'b1);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      idle(4);
    end

    // ---- drain ----
    guard = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d/%0d responses outstanding, required 0",
               exp_q0.size(), exp_q1.size());
    end
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
